// File: rtl/hot_page_addr_fetcher.sv
// hot_page_addr_fetcher
//
// Purpose: fetches one group of hot-page migration pairs from a host ring
// over an AXI4 read port and presents them, decoded into byte addresses
// and spread across migration channels, to the migration engine.
//
// Port summary:
//   axi4_mm_clk / axi4_mm_rst   clock, synchronous active-high reset
//   ring_base_paddr             host ring byte address (0 = ring not configured)
//   csr_mig_start_cnt           host trigger counter, each change queues one group
//   csr_aruser                  forwarded onto aruser while a read is requested
//   ar* / r*                    AXI4 read address / read data channels
//   src_addr, dst_addr          one 64-bit address per pair, channel-major
//   pair_mask                   1 = pair holds two non-zero pages
//   grp_valid / grp_ready       group handshake to the migration engine
//   err_sticky                  set by any non-OKAY read response, cleared by reset
//   grp_done_cnt                groups handed over since reset
//   pending_cnt                 queued triggers (saturates at 15)
//   dbg_state                   current FSM state
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. While valid is 1 and ready is 0 the sender holds valid
// and all payload signals stable. rready is always 1.

module hot_page_addr_fetcher #(
    parameter int NUM_CHAN       = 2,
    parameter int PAIRS_PER_CHAN = 8,
    parameter int RING_PAIRS     = 512
) (
    input  logic                                       axi4_mm_clk,
    input  logic                                       axi4_mm_rst,
    input  logic [63:0]                                ring_base_paddr,
    input  logic [63:0]                                csr_mig_start_cnt,
    input  logic [5:0]                                 csr_aruser,
    output logic [11:0]                                arid,
    output logic [63:0]                                araddr,
    output logic [5:0]                                 aruser,
    output logic                                       arvalid,
    input  logic                                       arready,
    input  logic [11:0]                                rid,
    input  logic [511:0]                               rdata,
    input  logic [1:0]                                 rresp,
    input  logic                                       rvalid,
    output logic                                       rready,
    output logic [NUM_CHAN*PAIRS_PER_CHAN*64-1:0]      src_addr,
    output logic [NUM_CHAN*PAIRS_PER_CHAN*64-1:0]      dst_addr,
    output logic [NUM_CHAN*PAIRS_PER_CHAN-1:0]         pair_mask,
    output logic                                       grp_valid,
    input  logic                                       grp_ready,
    output logic                                       err_sticky,
    output logic [63:0]                                grp_done_cnt,
    output logic [3:0]                                 pending_cnt,
    output logic [1:0]                                 dbg_state
);

    localparam int G          = NUM_CHAN * PAIRS_PER_CHAN;
    localparam int B          = G / 8;
    localparam int BW         = (B > 1) ? $clog2(B) : 1;
    localparam int RING_BEATS = RING_PAIRS / 8;
    localparam int RBW        = (RING_BEATS > 1) ? $clog2(RING_BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [63:0]        r_start_cnt;
    logic [3:0]         r_pending;
    logic [BW-1:0]      r_ar_beat;
    logic [BW:0]        r_rx_cnt;
    logic [RBW-1:0]     r_ring_beat;   // ring position in 64 B beats (8 pairs each)
    logic               r_grp_err;
    logic               r_err_sticky;
    logic [63:0]        r_done_cnt;
    logic [511:0]       r_beat_buf [B];

    logic [G*64-1:0]    r_src;
    logic [G*64-1:0]    r_dst;
    logic [G-1:0]       r_mask;

    logic [G*64-1:0]    w_src;
    logic [G*64-1:0]    w_dst;
    logic [G-1:0]       w_mask;

    logic               w_trig;
    logic               w_leave_idle;
    logic               w_ar_fire;
    logic               w_r_take;
    logic [BW-1:0]      w_rid_idx;
    logic               w_unused;

    assign w_trig       = (csr_mig_start_cnt != r_start_cnt);
    assign w_leave_idle = (r_state == ST_IDLE) && (w_next_state == ST_REQ);
    assign w_ar_fire    = (r_state == ST_REQ) && arready;
    // R beats are only meaningful while a group is being fetched; anything
    // else (e.g. leftovers of a group abandoned by reset) is dropped.
    assign w_r_take     = rvalid && ((r_state == ST_REQ) || (r_state == ST_WAIT));
    assign w_rid_idx    = (B > 1) ? rid[BW-1:0] : '0;
    assign w_unused     = ^rid;

    // ---------------- FSM ----------------
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        arvalid      = 1'b0;
        arid         = '0;
        araddr       = '0;
        aruser       = '0;
        grp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_pending != 4'd0) && (ring_base_paddr != 64'd0)) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                arvalid = 1'b1;
                arid    = 12'(r_ar_beat);
                aruser  = csr_aruser;
                araddr  = ring_base_paddr
                        + ((64'(r_ring_beat) + 64'(r_ar_beat)) << 6);
                if (arready && (r_ar_beat == BW'(B - 1))) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_rx_cnt == (BW + 1)'(B)) begin
                    w_next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                grp_valid = 1'b1;
                if (grp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- trigger queue ----------------
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            r_start_cnt <= csr_mig_start_cnt;
            r_pending   <= '0;
        end else begin
            r_start_cnt <= csr_mig_start_cnt;
            case ({w_trig, w_leave_idle})
                2'b10: if (r_pending != 4'hF) r_pending <= r_pending + 4'd1;
                2'b01: r_pending <= r_pending - 4'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // ---------------- fetch bookkeeping ----------------
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            r_ar_beat    <= '0;
            r_rx_cnt     <= '0;
            r_grp_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_leave_idle) begin
                r_ar_beat <= '0;
                r_rx_cnt  <= '0;
                r_grp_err <= 1'b0;
            end else begin
                if (w_ar_fire) begin
                    r_ar_beat <= r_ar_beat + BW'(1);
                end
                if (w_r_take) begin
                    r_rx_cnt <= r_rx_cnt + (BW + 1)'(1);
                    if (rresp != 2'b00) begin
                        r_grp_err <= 1'b1;
                    end
                end
            end
            if (w_r_take && (rresp != 2'b00)) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    // Beat storage is indexed by rid, so beats may return in any order.
    always_ff @(posedge axi4_mm_clk) begin
        if (w_r_take && (32'(w_rid_idx) < B)) begin
            r_beat_buf[w_rid_idx] <= rdata;
        end
    end

    // ---------------- pair decode ----------------
    // Global pair g lives in beat g/8, lane g%8; it is dealt round-robin
    // onto channels, so it lands at channel g%NUM_CHAN, slot g/NUM_CHAN.
    always_comb begin
        w_src  = '0;
        w_dst  = '0;
        w_mask = '0;
        for (int g = 0; g < G; g++) begin
            w_src[((g % NUM_CHAN) * PAIRS_PER_CHAN + g / NUM_CHAN) * 64 +: 64] =
                {20'b0, r_beat_buf[g / 8][(g % 8) * 64 +: 32], 12'b0};
            w_dst[((g % NUM_CHAN) * PAIRS_PER_CHAN + g / NUM_CHAN) * 64 +: 64] =
                {20'b0, r_beat_buf[g / 8][(g % 8) * 64 + 32 +: 32], 12'b0};
            w_mask[(g % NUM_CHAN) * PAIRS_PER_CHAN + g / NUM_CHAN] =
                (r_beat_buf[g / 8][(g % 8) * 64 +: 32] != 32'd0) &&
                (r_beat_buf[g / 8][(g % 8) * 64 + 32 +: 32] != 32'd0) &&
                !r_grp_err;
        end
    end

    // ---------------- presentation / ring advance ----------------
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_mask      <= '0;
            r_ring_beat <= '0;
            r_done_cnt  <= '0;
        end else if ((r_state == ST_WAIT) && (w_next_state == ST_PRESENT)) begin
            r_src  <= w_src;
            r_dst  <= w_dst;
            r_mask <= w_mask;
        end else if ((r_state == ST_PRESENT) && grp_ready) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_mask      <= '0;
            // Ring size is a power of two, so natural overflow is the wrap.
            r_ring_beat <= r_ring_beat + RBW'(B);
            r_done_cnt  <= r_done_cnt + 64'd1;
        end
    end

    assign rready       = 1'b1;
    assign src_addr     = r_src;
    assign dst_addr     = r_dst;
    assign pair_mask    = r_mask;
    assign err_sticky   = r_err_sticky;
    assign grp_done_cnt = r_done_cnt;
    assign pending_cnt  = r_pending;
    assign dbg_state    = r_state;

endmodule
